// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter.
// Holds the arbiter state encoding, the address-segment constants used by
// the virtual-to-physical translation, and the default ack timeout.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS_I = 2'd1,
        ST_BUS_D = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Segment bounds on addr[31:28]. The 0x8-0x9 window maps onto physical
    // 0x0-0x1 cached. The 0xA-0xB window maps onto the same physical range
    // but uncached.
    localparam logic [3:0] SEG_CACHED_LO   = 4'h8;
    localparam logic [3:0] SEG_CACHED_HI   = 4'h9;
    localparam logic [3:0] SEG_UNCACHED_LO = 4'hA;
    localparam logic [3:0] SEG_UNCACHED_HI = 4'hB;

    localparam int DEFAULT_TIMEOUT = 255;

    // Wide enough for TIMEOUT up to 65535.
    localparam int CNT_W = 16;

endpackage

// File: rtl/mem_bus_arbiter_addr_xlate.sv
// addr_xlate: combinational virtual-to-physical address translation.
// Ports:
//   addr     in  32  virtual address
//   paddr    out 32  physical address (only bits 31:28 are ever remapped)
//   uncached out 1   high for the 0xA-0xB segment
module addr_xlate
    import mem_bus_arbiter_pkg::*;
(
    input  logic [31:0] addr,
    output logic [31:0] paddr,
    output logic        uncached
);

    logic [3:0] seg;

    assign seg = addr[31:28];

    always_comb begin
        paddr    = addr;
        uncached = 1'b0;
        if (seg >= SEG_CACHED_LO && seg <= SEG_CACHED_HI) begin
            paddr[31:28] = seg - SEG_CACHED_LO;
        end else if (seg >= SEG_UNCACHED_LO && seg <= SEG_UNCACHED_HI) begin
            paddr[31:28] = seg - SEG_UNCACHED_LO;
            uncached     = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates an instruction-read port and a data port onto
// one shared memory bus. Virtual addresses are translated on the way out.
// Ties are broken in favour of the requester that was not granted last.
// A transaction ends on bus_ack, or is aborted with an error after TIMEOUT
// bus cycles without an ack.
// Ports:
//   clk, rst (synchronous, active-low)
//   inst_req/inst_addr              -> inst_rdata/inst_ready/inst_err
//   data_req/we/sel/addr/wdata      -> data_rdata/data_ready/data_err
//   bus_req/we/sel/addr/wdata/uncached (registered request), bus_rdata/bus_ack
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ready,
    output logic        inst_err,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ready,
    output logic        data_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              last_data_reg, last_data_next;   // 1: data was granted last
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_we_reg, bus_we_next;
    logic [3:0]        bus_sel_reg, bus_sel_next;
    logic [31:0]       bus_addr_reg, bus_addr_next;
    logic [31:0]       bus_wdata_reg, bus_wdata_next;
    logic              bus_uncached_reg, bus_uncached_next;
    logic [31:0]       inst_rdata_reg, inst_rdata_next;
    logic              inst_ready_reg, inst_ready_next;
    logic              inst_err_reg, inst_err_next;
    logic [31:0]       data_rdata_reg, data_rdata_next;
    logic              data_ready_reg, data_ready_next;
    logic              data_err_reg, data_err_next;

    logic              pick_data, pick_inst, timed_out;
    logic [31:0]       sel_addr, xl_paddr;
    logic              xl_uncached;

    // Data wins a tie unless it was the last one served.
    assign pick_data = data_req && (!inst_req || !last_data_reg);
    assign pick_inst = inst_req && !pick_data;
    assign sel_addr  = pick_data ? data_addr : inst_addr;
    assign timed_out = (cnt_reg == CNT_LAST);

    addr_xlate u_xlate (
        .addr     (sel_addr),
        .paddr    (xl_paddr),
        .uncached (xl_uncached)
    );

    always_comb begin
        state_next        = state_reg;
        last_data_next    = last_data_reg;
        cnt_next          = cnt_reg;
        bus_req_next      = bus_req_reg;
        bus_we_next       = bus_we_reg;
        bus_sel_next      = bus_sel_reg;
        bus_addr_next     = bus_addr_reg;
        bus_wdata_next    = bus_wdata_reg;
        bus_uncached_next = bus_uncached_reg;
        inst_rdata_next   = inst_rdata_reg;
        inst_ready_next   = 1'b0;
        inst_err_next     = 1'b0;
        data_rdata_next   = data_rdata_reg;
        data_ready_next   = 1'b0;
        data_err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_data || pick_inst) begin
                    state_next        = pick_data ? ST_BUS_D : ST_BUS_I;
                    last_data_next    = pick_data;
                    cnt_next          = '0;
                    bus_req_next      = 1'b1;
                    bus_addr_next     = xl_paddr;
                    bus_uncached_next = xl_uncached;
                    bus_we_next       = pick_data && data_we;
                    bus_sel_next      = pick_data ? data_sel : 4'hF;
                    bus_wdata_next    = pick_data ? data_wdata : 32'h0;
                end
            end
            ST_BUS_I, ST_BUS_D: begin
                // An ack in the timeout cycle still counts as a normal completion.
                if (bus_ack || timed_out) begin
                    state_next   = ST_DONE;
                    bus_req_next = 1'b0;
                    if (state_reg == ST_BUS_D) begin
                        data_ready_next = 1'b1;
                        data_err_next   = !bus_ack;
                        data_rdata_next = (bus_ack && !bus_we_reg) ? bus_rdata : 32'h0;
                    end else begin
                        inst_ready_next = 1'b1;
                        inst_err_next   = !bus_ack;
                        inst_rdata_next = bus_ack ? bus_rdata : 32'h0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            last_data_reg    <= 1'b0;
            cnt_reg          <= '0;
            bus_req_reg      <= 1'b0;
            bus_we_reg       <= 1'b0;
            bus_sel_reg      <= 4'h0;
            bus_addr_reg     <= 32'h0;
            bus_wdata_reg    <= 32'h0;
            bus_uncached_reg <= 1'b0;
            inst_rdata_reg   <= 32'h0;
            inst_ready_reg   <= 1'b0;
            inst_err_reg     <= 1'b0;
            data_rdata_reg   <= 32'h0;
            data_ready_reg   <= 1'b0;
            data_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            last_data_reg    <= last_data_next;
            cnt_reg          <= cnt_next;
            bus_req_reg      <= bus_req_next;
            bus_we_reg       <= bus_we_next;
            bus_sel_reg      <= bus_sel_next;
            bus_addr_reg     <= bus_addr_next;
            bus_wdata_reg    <= bus_wdata_next;
            bus_uncached_reg <= bus_uncached_next;
            inst_rdata_reg   <= inst_rdata_next;
            inst_ready_reg   <= inst_ready_next;
            inst_err_reg     <= inst_err_next;
            data_rdata_reg   <= data_rdata_next;
            data_ready_reg   <= data_ready_next;
            data_err_reg     <= data_err_next;
        end
    end

    assign bus_req      = bus_req_reg;
    assign bus_we       = bus_we_reg;
    assign bus_sel      = bus_sel_reg;
    assign bus_addr     = bus_addr_reg;
    assign bus_wdata    = bus_wdata_reg;
    assign bus_uncached = bus_uncached_reg;
    assign inst_rdata   = inst_rdata_reg;
    assign inst_ready   = inst_ready_reg;
    assign inst_err     = inst_err_reg;
    assign data_rdata   = data_rdata_reg;
    assign data_ready   = data_ready_reg;
    assign data_err     = data_err_reg;

endmodule
